// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, renderer-visible player states
// and the vertical-motion FSM encoding. Also used by the graphics block.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned SPRITE_W = 64;

  localparam logic [3:0] STATE_STANDING = 4'd0;
  localparam logic [3:0] STATE_JUMP     = 4'd1;

  typedef enum logic [0:0] {
    V_STANDING = 1'b0,
    V_JUMP     = 1'b1
  } vstate_e;

  // Saturate an 11-bit signed value into [lo, hi]; the extra sign bit keeps
  // out-of-range results from wrapping at 0 or 1023.
  function automatic logic signed [10:0] clamp11(
    input logic signed [10:0] v,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi
  );
    logic signed [10:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for a raw button level that is asynchronous to clk.
module button_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/player_motion.sv
// Per-player movement controller: turns synchronised left/right/jump levels
// into a sprite top-left position and an animation state, updated only on
// the frame tick so the renderer sees stable values for a whole frame.
module player_motion
  import game_pkg::*;
#(
  parameter int START_X   = 100,
  parameter int GROUND_Y  = 380,
  parameter int MIN_X     = 0,
  parameter int MAX_X     = 576,
  parameter int WALK_STEP = 2,
  parameter int JUMP_V0   = 12,
  parameter int GRAVITY   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [3:0] state
);

  localparam logic signed [10:0] MIN_X_S    = 11'(MIN_X);
  localparam logic signed [10:0] MAX_X_S    = 11'(MAX_X);
  localparam logic signed [10:0] STEP_S     = 11'(WALK_STEP);
  localparam logic signed [10:0] GROUND_S   = 11'(GROUND_Y);
  localparam logic [9:0]         START_X_U  = 10'(START_X);
  localparam logic [9:0]         GROUND_U   = 10'(GROUND_Y);
  localparam logic [9:0]         LAUNCH_Y_U = 10'(GROUND_Y - JUMP_V0);
  localparam logic signed [7:0]  LAUNCH_VY  = 8'(GRAVITY - JUMP_V0);
  localparam logic signed [7:0]  GRAVITY_S  = 8'(GRAVITY);

  logic l_s, r_s, j_s;

  vstate_e           state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic signed [7:0] vy_q, vy_d;
  logic              jump_armed_q, jump_armed_d;

  logic signed [10:0] x_cur, x_cand, x_next;
  logic signed [10:0] y_next;

  button_sync u_sync_left  (.clk(clk), .rst_n(rst), .d_i(btn_left),  .q_o(l_s));
  button_sync u_sync_right (.clk(clk), .rst_n(rst), .d_i(btn_right), .q_o(r_s));
  button_sync u_sync_jump  (.clk(clk), .rst_n(rst), .d_i(btn_jump),  .q_o(j_s));

  // Horizontal candidate and clamp, plus the unclamped vertical step.
  always_comb begin
    x_cur = signed'({1'b0, pos_x_q});
    if (l_s && !r_s) begin
      x_cand = x_cur - STEP_S;
    end else if (r_s && !l_s) begin
      x_cand = x_cur + STEP_S;
    end else begin
      x_cand = x_cur;
    end
    x_next = clamp11(x_cand, MIN_X_S, MAX_X_S);
    y_next = signed'({1'b0, pos_y_q}) + {{3{vy_q[7]}}, vy_q};
  end

  // Next-state logic: everything holds except on a frame tick.
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    vy_d         = vy_q;
    jump_armed_d = jump_armed_q;
    if (frame_tick) begin
      pos_x_d = x_next[9:0];
      // Re-arm only once the button has been seen released on a tick, so a
      // held button never produces a second jump.
      if (!j_s) begin
        jump_armed_d = 1'b1;
      end else begin
        jump_armed_d = jump_armed_q;
      end
      case (state_q)
        V_STANDING: begin
          if (j_s && jump_armed_q) begin
            state_d      = V_JUMP;
            vy_d         = LAUNCH_VY;
            pos_y_d      = LAUNCH_Y_U;
            jump_armed_d = 1'b0;
          end else begin
            pos_y_d = GROUND_U;
            vy_d    = 8'sd0;
          end
        end
        V_JUMP: begin
          // Landing never relaunches on the same tick; that is left to the
          // STANDING branch on a later tick.
          if (y_next >= GROUND_S) begin
            state_d = V_STANDING;
            pos_y_d = GROUND_U;
            vy_d    = 8'sd0;
          end else if (y_next < 11'sd0) begin
            pos_y_d = 10'd0;
            vy_d    = vy_q + GRAVITY_S;
          end else begin
            pos_y_d = y_next[9:0];
            vy_d    = vy_q + GRAVITY_S;
          end
        end
        default: begin
          state_d = V_STANDING;
          pos_y_d = GROUND_U;
          vy_d    = 8'sd0;
        end
      endcase
    end else begin
      state_d = state_q;
      pos_x_d = pos_x_q;
    end
  end

  // State, position and velocity registers; reset lands the player at start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= V_STANDING;
      pos_x_q      <= START_X_U;
      pos_y_q      <= GROUND_U;
      vy_q         <= 8'sd0;
      jump_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      vy_q         <= vy_d;
      jump_armed_q <= jump_armed_d;
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign state = (state_q == V_JUMP) ? STATE_JUMP : STATE_STANDING;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: idle, walking with clamps, jump arc,
// jump-while-walking and asynchronous reset in mid-air.
module tb_player_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_jump = 1'b0;
  logic [9:0] pos_x, pos_y, e_x, e_y;
  logic [3:0] state, e_state;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_x;

  always #5 clk = ~clk;

  player_motion u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .pos_x(pos_x), .pos_y(pos_y), .state(state)
  );

  // Second instance starting at x = 1 to exercise the left clamp from an odd x.
  player_motion #(.START_X(1)) u_dut_edge (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .pos_x(e_x), .pos_y(e_y), .state(e_state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Let buttons settle through the synchroniser, then pulse one frame tick;
  // returns on the following falling edge with outputs updated.
  task automatic tick();
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_x", int'(pos_x), 100);
    check("rst_y", int'(pos_y), 380);
    check("rst_state", int'(state), 0);
    check("rst_edge_x", int'(e_x), 1);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_x", int'(pos_x), 100);
      check("idle_y", int'(pos_y), 380);
      check("idle_state", int'(state), 0);
    end

    btn_left = 1'b1;
    tick();
    check("left_x", int'(pos_x), 98);
    check("left_edge_x_from1", int'(e_x), 0);
    tick();
    check("left_x2", int'(pos_x), 96);
    check("left_edge_x_at0", int'(e_x), 0);

    btn_right = 1'b1;
    tick();
    check("both_x", int'(pos_x), 96);
    check("both_edge_x", int'(e_x), 0);

    btn_left = 1'b0;
    exp_x = 96;
    for (int i = 0; i < 300; i++) begin
      tick();
      exp_x = (exp_x + 2 > 576) ? 576 : exp_x + 2;
      check("right_walk_x", int'(pos_x), exp_x);
    end
    check("right_clamp_x", int'(pos_x), 576);
    btn_right = 1'b0;

    btn_jump = 1'b1;
    tick();
    check("jump1_state", int'(state), 1);
    check("jump1_y", int'(pos_y), 368);
    repeat (5) @(negedge clk);
    check("jump_stable_y", int'(pos_y), 368);
    for (int t = 2; t <= 25; t++) begin
      tick();
      if (t == 6)  check("jump6_y", int'(pos_y), 323);
      if (t == 12) check("jump12_apex_y", int'(pos_y), 302);
      if (t == 24) check("jump24_y", int'(pos_y), 368);
      if (t == 25) begin
        check("jump25_y", int'(pos_y), 380);
        check("jump25_state", int'(state), 0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_no_rejump_state", int'(state), 0);
      check("held_no_rejump_y", int'(pos_y), 380);
    end
    check("jump_x_unchanged", int'(pos_x), 576);
    btn_jump = 1'b0;
    tick();

    btn_left = 1'b1;
    repeat (50) tick();
    check("left50_x", int'(pos_x), 476);
    btn_left = 1'b0;

    btn_right = 1'b1;
    btn_jump  = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      check("walkjump_x", int'(pos_x), 476 + 2 * t);
      if (t == 1) begin
        check("walkjump1_state", int'(state), 1);
        check("walkjump1_y", int'(pos_y), 368);
      end
      if (t == 12) check("walkjump12_y", int'(pos_y), 302);
      if (t == 25) begin
        check("walkjump25_y", int'(pos_y), 380);
        check("walkjump25_state", int'(state), 0);
      end
    end
    btn_right = 1'b0;
    btn_jump  = 1'b0;
    tick();
    check("after_walkjump_x", int'(pos_x), 526);

    btn_jump = 1'b1;
    repeat (6) tick();
    check("prereset_y", int'(pos_y), 323);
    check("prereset_state", int'(state), 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_x", int'(pos_x), 100);
    check("midrst_y", int'(pos_y), 380);
    check("midrst_state", int'(state), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_state", int'(state), 0);
      check("postrst_y", int'(pos_y), 380);
      check("postrst_x", int'(pos_x), 100);
    end
    btn_jump = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/player_motion.md
# player_motion

Per-player movement controller that sits directly upstream of the graphics renderer. It converts debounced left/right/jump button levels into a sprite top-left position and a 4-bit animation state, and it drives `p*_x`, `p*_y` and `p*_state` of the renderer. All position updates happen only on a one-cycle frame tick, so the coordinates stay stable for the whole active video frame. The design has one instance per player.

## Interface
Parameters:
- `START_X`, default 100: x position after reset.
- `GROUND_Y`, default 380: y position of the standing sprite (floor).
- `MIN_X`, default 0: leftmost legal x.
- `MAX_X`, default 576: rightmost legal x (640 minus a 64-pixel sprite width).
- `WALK_STEP`, default 2: pixels moved per frame tick while walking.
- `JUMP_V0`, default 12: initial upward speed, in pixels per tick.
- `GRAVITY`, default 1: velocity increment per tick.

Ports:
- `clk`, input, 1: core clock (50 MHz).
- `rst`, input, 1: asynchronous, active-low reset.
- `frame_tick`, input, 1: one-cycle pulse, once per frame, during vertical blank.
- `btn_left`, input, 1: raw button level, asynchronous to `clk`.
- `btn_right`, input, 1: raw button level, asynchronous to `clk`.
- `btn_jump`, input, 1: raw button level, asynchronous to `clk`.
- `pos_x`, output, 10: sprite left column, registered.
- `pos_y`, output, 10: sprite top row, registered.
- `state`, output, 4: `STATE_STANDING` = 4'd0, `STATE_JUMP` = 4'd1.

## Operation
- **Input synchronisation:** each button passes through a 2-flop synchroniser. The synchronised signals are `l_s`, `r_s` and `j_s`.
- **Jump arming:** `jump_armed` is set whenever `j_s` = 0. It is cleared when a jump launches. This means one press gives exactly one jump, and holding the button does not re-jump.
- **Gating:** nothing changes on cycles where `frame_tick` = 0.
- **Horizontal motion** (applies on each tick, in both states):
  - `l_s` & !`r_s`: `pos_x` becomes max(`pos_x` − `WALK_STEP`, `MIN_X`).
  - `r_s` & !`l_s`: `pos_x` becomes min(`pos_x` + `WALK_STEP`, `MAX_X`).
  - Both or neither: `pos_x` holds.
  - Clamping is computed in 11-bit signed arithmetic, so there is no wrap at 0 or 1023.
- **Vertical FSM** (uses signed 8-bit velocity `vy`):
  - **STANDING**, tick with `j_s` & `jump_armed`: go to JUMP, set `vy` = `GRAVITY` − `JUMP_V0`, set `pos_y` = `GROUND_Y` − `JUMP_V0`, and clear `jump_armed`. On any other tick, `pos_y` = `GROUND_Y` and `vy` = 0.
  - **JUMP**, each tick: compute `y_next` = `pos_y` + `vy` in 11-bit signed arithmetic.
    - If `y_next` ≥ `GROUND_Y`: set `pos_y` = `GROUND_Y`, `vy` = 0, and go to STANDING.
    - Else if `y_next` < 0: set `pos_y` = 0 and `vy` += `GRAVITY`.
    - Else: set `pos_y` = `y_next` and `vy` += `GRAVITY`.
- **Simultaneous events:** landing and a held jump on the same tick do not relaunch. The earliest relaunch is the next tick, and only if the player is armed.
- **Reset mid-jump:** reset immediately forces STANDING at the start position.

## Timing
- **Reset values:** `pos_x` = `START_X`, `pos_y` = `GROUND_Y`, `state` = 0, `vy` = 0, `jump_armed` = 0, synchroniser flops = 0.
- **Button latency:** a button edge is visible to the FSM 2 clocks later. A press must be stable before the tick by ≥2 cycles to count on that tick.
- **Output update:** outputs update on the clock edge that samples `frame_tick` = 1. This is a single-cycle update with no further latency.
- **Output stability:** outputs are constant between ticks.
- **Jump duration:** with the defaults, the full arc lasts 25 ticks. The apex is `pos_y` = 302 at tick 12, and the player lands at tick 25.

## Structure
- **Shared package `game_pkg`:** `STATE_STANDING`, `STATE_JUMP`, and the screen-dimension constants. The graphics block uses the same package.
- **Sub-module `button_sync`:** the 2-flop synchroniser, instantiated once per button.
- **FSM and datapath:** remain in `player_motion`.

## Test plan
- **Reset and idle:** release reset with no buttons pressed and 3 ticks applied. Required: `pos_x` = 100, `pos_y` = 380, `state` = 0 throughout.
- **Right walk with clamp:** hold right for 300 ticks. Required: `pos_x` increases by 2 per tick and saturates at 576. No wrap occurs, and the value never exceeds 576.
- **Left/both:** from x = 1, hold left for one tick. Required: x = 0. Then hold left and right together. Required: x holds.
- **Full jump:** press jump and hold it for the whole arc. Required:
  - Tick 1: `state` = 1, y = 368.
  - Tick 12: y = 302.
  - Tick 25: y = 380, `state` = 0.
  - No second jump until the button is released and pressed again.
- **Jump with walk:** press right and jump together. Required: x advances 2 per tick during the arc, independent of y.
- **Reset mid-jump:** assert `rst` low at tick 6 of a jump, asynchronously and between clock edges. Required: outputs immediately show 100/380/0. No jump resumes after reset is released.
